fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction decode/control logic. It owns the fetch PC, issues one-at-a-time requests to instruction memory, and buffers returned instructions with their PCs in a 2-entry queue. Decode drains the queue through a valid/ready handshake. Redirects from branch/jump resolution flush the queue and discard any in-flight response.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on instr_o when the queue is empty
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_o  output  1  fetch request; memory always accepts in the same cycle
- imem_addr_o  output  ADDR_WIDTH  fetch address, word aligned, valid when imem_req_o=1
- imem_rvalid_i  input  1  response valid; in order, latency ≥1 cycle
- imem_rdata_i  input  INSTR_WIDTH  response instruction
- redirect_i  input  1  taken branch/jump: restart fetch at redirect_pc_i
- redirect_pc_i  input  ADDR_WIDTH  redirect target
- valid_o  output  1  queue head holds an instruction
- ready_i  input  1  decode accepts the head this cycle
- instr_o  output  INSTR_WIDTH  head instruction, NOP_INSTR when empty
- pc_o  output  ADDR_WIDTH  PC of head, 0 when empty
- pc_plus4_o  output  ADDR_WIDTH  pc_o+4, mod 2^ADDR_WIDTH

## Operation
- Registers: fetch_pc, 2-entry queue of {pc, instr}, occupancy count (0..2), FSM state.
- FSM states:
  - RUN: nothing outstanding.
  - WAIT: one request outstanding.
  - DRAIN: one outstanding response is to be discarded.
- Issue rule: imem_req_o=1 iff redirect_i=0 and one of:
  - state=RUN and count≤1.
  - state=WAIT and imem_rvalid_i=1 and the post-push/pop occupancy is ≤1.
- On issue: imem_addr_o=fetch_pc; fetch_pc←fetch_pc+4 (wraps); state←WAIT.
- Response in WAIT: push {pc of request, imem_rdata_i}. Without a new issue, state←RUN.
- Response in DRAIN: data dropped; state←RUN. No issue in that cycle.
- Pop: when valid_o&&ready_i, the head advances. Push and pop in the same cycle leave count unchanged, and order is preserved.
- Redirect (highest priority):
  - Queue flushed (count←0) and any same-cycle pop/push ignored.
  - fetch_pc←{redirect_pc_i[ADDR_WIDTH-1:2],2'b00}.
  - imem_req_o=0 that cycle.
  - State transition:
    - WAIT with imem_rvalid_i=0 → DRAIN.
    - WAIT with imem_rvalid_i=1 → RUN, response dropped.
    - DRAIN with imem_rvalid_i=0 → stays DRAIN.
    - DRAIN with imem_rvalid_i=1 → RUN.
    - RUN → RUN.
- imem_rvalid_i in RUN is illegal and ignored.
- Queue overflow is impossible by the issue rule. count=2 blocks issue.

## Timing
- Reset (rst_n=0, asynchronous):
  - fetch_pc=RESET_PC, count=0, state=RUN.
  - valid_o=0, instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=4.
  - imem_req_o=0 while rst_n=0.
- First cycle after rst_n rises: imem_req_o=1, imem_addr_o=RESET_PC (combinational from state).
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests must not be presented by memory after reset.
- Latency: response captured at edge N makes valid_o=1 from cycle N+1. Fetch-to-decode latency is memory latency + 1 cycle.
- With 1-cycle memory latency and ready_i=1: one instruction per cycle sustained.
- Redirect asserted in cycle T:
  - valid_o=0 in cycle T+1.
  - First request to the target is in T+1 if nothing is outstanding, else the cycle after the discarded response.
- instr_o, pc_o and pc_plus4_o are stable while valid_o=1 and ready_i=0.

## Test plan
- Reset release, RESET_PC=0, memory latency 1, ready_i=1 → requests at 0,4,8,… in consecutive cycles. valid_o rises 2 cycles after reset release; pc_o=0,4,8 with matching instr_o.
- ready_i=0 held → exactly 2 entries queue (pc 0,4), imem_req_o stays 0. ready_i→1 → 0 then 4 pop on successive cycles, and fetch resumes at 8.
- Latency 3, redirect to 0x100 one cycle after issue of 0x20 → response for 0x20 never appears on instr_o. Next request addr=0x100 in the cycle after the discarded response.
- Redirect to 0x200 in the same cycle as imem_rvalid_i for 0x40 → 0x40 dropped, queue empty, imem_req_o=1 with addr 0x200 next cycle.
- redirect_pc_i=0x0000_0103 → imem_addr_o=0x0000_0100.
- fetch_pc=0xFFFF_FFFC → request 0xFFFF_FFFC then 0x0000_0000. pc_plus4_o=0x0000_0000 when pc_o=0xFFFF_FFFC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one request in flight to
// instruction memory, and buffers returned {pc, instr} pairs in a 2-entry queue for decode.
module fetch_stage #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req_o,
    output logic [ADDR_WIDTH-1:0]   imem_addr_o,
    input  logic                    imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata_i,
    input  logic                    redirect_i,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [INSTR_WIDTH-1:0]  instr_o,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic [ADDR_WIDTH-1:0]   pc_plus4_o
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic [1:0]             count_q, count_d;
    logic                   head_q, head_d;

    logic [ADDR_WIDTH-1:0]  q_pc_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr_q [DEPTH];

    logic                   queue_valid;
    logic                   pop;
    logic                   rsp_wait;
    logic                   push;
    logic                   issue;
    logic                   tail;
    logic [1:0]             post_count;
    logic [ADDR_WIDTH-1:0]  redirect_aligned;

    // Handshake and occupancy bookkeeping shared by the FSM and the queue.
    always_comb begin
        queue_valid      = (count_q != 2'd0);
        pop              = queue_valid && ready_i;
        rsp_wait         = (state_q == ST_WAIT) && imem_rvalid_i;
        push             = rsp_wait && !redirect_i;
        post_count       = count_q + {1'b0, push} - {1'b0, pop};
        // A push only ever happens with at most one entry held, so the tail is head^count[0].
        tail             = head_q ^ count_q[0];
        redirect_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);
        issue            = rst_n && !redirect_i &&
                           (((state_q == ST_RUN) && (count_q <= 2'd1)) ||
                            (rsp_wait && (post_count <= 2'd1)));
    end

    // Next-state logic; a redirect overrides every other update in its cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        head_d     = head_q;

        if (redirect_i) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_aligned;
            unique case (state_q)
                ST_WAIT:  state_d = imem_rvalid_i ? ST_RUN : ST_DRAIN;
                ST_DRAIN: state_d = imem_rvalid_i ? ST_RUN : ST_DRAIN;
                default:  state_d = ST_RUN;
            endcase
        end else begin
            count_d = post_count;
            if (pop) begin
                head_d = ~head_q;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (issue) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = issue ? ST_WAIT : ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase

            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                req_pc_d   = fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // Queue entries: each slot captures the returning response when it is the tail.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic                   entry_we;
            logic [ADDR_WIDTH-1:0]  entry_pc_d;
            logic [INSTR_WIDTH-1:0] entry_instr_d;

            always_comb begin
                entry_we      = push && (tail == 1'(gi));
                entry_pc_d    = q_pc_q[gi];
                entry_instr_d = q_instr_q[gi];
                if (entry_we) begin
                    entry_pc_d    = req_pc_q;
                    entry_instr_d = imem_rdata_i;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_pc_q[gi]    <= '0;
                    q_instr_q[gi] <= '0;
                end else begin
                    q_pc_q[gi]    <= entry_pc_d;
                    q_instr_q[gi] <= entry_instr_d;
                end
            end
        end
    endgenerate

    always_comb begin
        imem_req_o  = issue;
        imem_addr_o = fetch_pc_q;
        valid_o     = queue_valid;
        instr_o     = queue_valid ? q_instr_q[head_q] : NOP_INSTR;
        pc_o        = queue_valid ? q_pc_q[head_q] : '0;
        pc_plus4_o  = pc_o + ADDR_WIDTH'(4);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small in-order memory responder with programmable
// latency, and hand-computed expectations checked by immediate assertions.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    int n_checks = 0;
    int n_fail   = 0;

    int          lat;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    bit          req_s;
    logic [31:0] addr_s;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample the request, take the edge, then present any due response.
    // Memory returns addr ^ 32'hDEAD_0000 as the instruction word.
    task automatic tick();
        #2;
        req_s  = imem_req_o;
        addr_s = imem_addr_o;
        if (req_s) $display("request addr=%h latency=%0d", addr_s, lat);
        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (req_s) begin
            mem_pend = 1'b1;
            mem_addr = addr_s;
            mem_cnt  = lat;
        end
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_addr ^ 32'hDEAD_0000;
                mem_pend      = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
    endtask

    task automatic reset_assert();
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        mem_pend      = 1'b0;
        #1;
    endtask

    task automatic reset_release(input int l);
        lat = l;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic redirect_cycle(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        #1;
        chk1("redirect_blocks_req", imem_req_o, 1'b0);
        tick();
        redirect_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        lat           = 1;
        mem_pend      = 1'b0;
        mem_addr      = 32'h0;
        mem_cnt       = 0;
        #2;

        // Reset values
        chk1("rst_valid", valid_o, 1'b0);
        chk ("rst_instr", instr_o, 32'h0000_0013);
        chk ("rst_pc", pc_o, 32'h0);
        chk ("rst_pc4", pc_plus4_o, 32'h4);
        chk1("rst_req", imem_req_o, 1'b0);

        // Streaming with 1-cycle memory and ready=1
        reset_release(1);
        chk1("a0_req", imem_req_o, 1'b1);
        chk ("a0_addr", imem_addr_o, 32'h0);
        tick();
        chk1("a1_valid", valid_o, 1'b0);
        chk1("a1_req", imem_req_o, 1'b1);
        chk ("a1_addr", imem_addr_o, 32'h4);
        tick();
        chk1("a2_valid", valid_o, 1'b1);
        chk ("a2_pc", pc_o, 32'h0);
        chk ("a2_instr", instr_o, 32'hDEAD_0000);
        chk ("a2_pc4", pc_plus4_o, 32'h4);
        chk ("a2_addr", imem_addr_o, 32'h8);
        tick();
        chk ("a3_pc", pc_o, 32'h4);
        chk ("a3_instr", instr_o, 32'hDEAD_0004);
        chk ("a3_addr", imem_addr_o, 32'hC);

        // Asynchronous reset mid-operation
        reset_assert();
        chk1("mrst_valid", valid_o, 1'b0);
        chk1("mrst_req", imem_req_o, 1'b0);
        chk ("mrst_pc", pc_o, 32'h0);
        chk ("mrst_instr", instr_o, 32'h0000_0013);

        // Backpressure: queue fills to two entries and fetch stalls
        ready_i = 1'b0;
        reset_release(1);
        chk ("b0_addr", imem_addr_o, 32'h0);
        tick();
        chk ("b1_addr", imem_addr_o, 32'h4);
        tick();
        chk1("b2_valid", valid_o, 1'b1);
        chk ("b2_pc", pc_o, 32'h0);
        chk1("b2_req", imem_req_o, 1'b0);
        tick();
        chk1("b3_req", imem_req_o, 1'b0);
        chk ("b3_instr", instr_o, 32'hDEAD_0000);
        tick();
        chk ("b4_pc_hold", pc_o, 32'h0);
        chk ("b4_instr_hold", instr_o, 32'hDEAD_0000);
        ready_i = 1'b1;
        #1;
        chk1("b4_req", imem_req_o, 1'b0);
        tick();
        chk ("b5_pc", pc_o, 32'h4);
        chk ("b5_instr", instr_o, 32'hDEAD_0004);
        chk1("b5_req", imem_req_o, 1'b1);
        chk ("b5_addr", imem_addr_o, 32'h8);
        tick();
        chk1("b6_valid", valid_o, 1'b0);
        chk ("b6_addr", imem_addr_o, 32'hC);
        tick();
        chk ("b7_pc", pc_o, 32'h8);
        chk ("b7_instr", instr_o, 32'hDEAD_0008);

        // Redirect while a 3-cycle response is in flight; 0x103 aligns to 0x100
        reset_assert();
        reset_release(3);
        redirect_cycle(32'h0000_0020);
        chk1("c1_req", imem_req_o, 1'b1);
        chk ("c1_addr", imem_addr_o, 32'h20);
        tick();
        redirect_cycle(32'h0000_0103);
        chk1("c3_req", imem_req_o, 1'b0);
        chk1("c3_valid", valid_o, 1'b0);
        tick();
        chk1("c4_rvalid_seen", imem_rvalid_i, 1'b1);
        chk1("c4_req", imem_req_o, 1'b0);
        chk1("c4_valid", valid_o, 1'b0);
        tick();
        chk1("c5_req", imem_req_o, 1'b1);
        chk ("c5_addr", imem_addr_o, 32'h100);
        chk1("c5_valid", valid_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("c67_valid", valid_o, 1'b0);
            chk1("c67_req", imem_req_o, 1'b0);
        end
        tick();
        chk ("c8_addr", imem_addr_o, 32'h104);
        tick();
        chk1("c9_valid", valid_o, 1'b1);
        chk ("c9_pc", pc_o, 32'h100);
        chk ("c9_instr", instr_o, 32'hDEAD_0100);
        chk ("c9_pc4", pc_plus4_o, 32'h104);

        // Redirect coinciding with the response for 0x40
        reset_assert();
        reset_release(2);
        redirect_cycle(32'h0000_0040);
        chk ("d1_addr", imem_addr_o, 32'h40);
        tick();
        chk1("d2_req", imem_req_o, 1'b0);
        tick();
        chk1("d3_rvalid_seen", imem_rvalid_i, 1'b1);
        redirect_cycle(32'h0000_0200);
        chk1("d4_valid", valid_o, 1'b0);
        chk ("d4_instr", instr_o, 32'h0000_0013);
        chk1("d4_req", imem_req_o, 1'b1);
        chk ("d4_addr", imem_addr_o, 32'h200);
        tick();
        chk1("d5_valid", valid_o, 1'b0);

        // Fetch PC wraps from the top of the address space
        reset_assert();
        reset_release(1);
        redirect_cycle(32'hFFFF_FFFC);
        chk ("e1_addr", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        chk ("e2_addr", imem_addr_o, 32'h0);
        chk1("e2_valid", valid_o, 1'b0);
        tick();
        chk ("e3_pc", pc_o, 32'hFFFF_FFFC);
        chk ("e3_pc4", pc_plus4_o, 32'h0);
        chk ("e3_instr", instr_o, 32'h2152_FFFC);
        chk ("e3_addr", imem_addr_o, 32'h4);
        tick();
        chk ("e4_pc", pc_o, 32'h0);
        chk ("e4_instr", instr_o, 32'hDEAD_0000);
        chk ("e4_pc4", pc_plus4_o, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
